// File: rtl/my_alu_pkg.sv
// Shared types and helpers for the pipelined Hack-style ALU.
// Holds the control-word layout and the operand pre-processing used by both operand paths.
package my_alu_pkg;

  localparam int WORD_W = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  // Zero the operand first, then optionally invert the result.
  function automatic logic [WORD_W-1:0] preprocess(input logic [WORD_W-1:0] v,
                                                   input logic              z,
                                                   input logic              n);
    logic [WORD_W-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

endpackage

// File: rtl/my_and_16.sv
// 16-bit bitwise AND stage.
// Purely combinational; the caller is responsible for registering the result.
module my_and_16
  import my_alu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/my_alu_16_pipe.sv
// Two-stage pipelined 16-bit Hack-style ALU with valid/ready on both sides.
// S1 holds pre-processed operands, S2 holds the final result and its flags.
module my_alu_16_pipe
  import my_alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [5:0]        ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out,
  output logic              zr,
  output logic              ng,
  output logic [CNT_W-1:0]  op_count
);

  alu_ctrl_t         c;
  logic              s1_valid;
  logic [WORD_W-1:0] s1_x;
  logic [WORD_W-1:0] s1_y;
  logic              s1_f;
  logic              s1_no;
  logic              s1_adv;
  logic              s2_adv;
  logic [WORD_W-1:0] and_r;
  logic [WORD_W-1:0] sum_r;
  logic [WORD_W-1:0] res;

  assign c = alu_ctrl_t'(ctrl);

  // Backpressure flows from the output only; in_valid never feeds in_ready.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, which is what makes the
  // two stages shift together cleanly in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x  <= preprocess(x, c.zx, c.nx);
        s1_y  <= preprocess(y, c.zy, c.ny);
        s1_f  <= c.f;
        s1_no <= c.no;
      end
    end
  end

  my_and_16 u_and (
    .a (s1_x),
    .b (s1_y),
    .y (and_r)
  );

  assign sum_r = s1_x + s1_y;
  assign res   = s1_no ? ~(s1_f ? sum_r : and_r) : (s1_f ? sum_r : and_r);

  // A bubble moving in clears out_valid but leaves the stale data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= res;
        zr  <= (res == '0);
        ng  <= res[WORD_W-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_my_alu_16_pipe.sv
// Directed self-checking bench for my_alu_16_pipe.
// Inputs change and outputs are sampled around the falling edge; the DUT acts on the rising edge.
module tb_my_alu_16_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_alu_16_pipe #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a falling edge and check the result exactly two edges after acceptance.
  task automatic one_beat(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic [5:0] cv, input logic [15:0] e_out,
                          input logic e_zr, input logic e_ng);
    x = xv; y = yv; ctrl = cv; in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out, e_out);
    check({tag, "_zr"}, zr, e_zr);
    check({tag, "_ng"}, ng, e_ng);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  logic [15:0] stall_exp [4];
  logic [15:0] stall_x   [4];
  logic [15:0] stall_y   [4];
  logic [5:0]  stall_c   [4];

  initial begin
    int idx_in;
    int got;
    int cyc;
    bit acc_in;
    bit acc_out;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; ctrl = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_zr", zr, 0);
    check("rst_ng", ng, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    one_beat("add_5_3",   16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0);
    one_beat("and",       16'hE000, 16'hA000, 6'b000000, 16'hA000, 1'b0, 1'b1);
    one_beat("zero",      16'hE000, 16'hA000, 6'b101010, 16'h0000, 1'b1, 1'b0);
    one_beat("x_minus_y", 16'h0003, 16'h0005, 6'b010011, 16'hFFFE, 1'b0, 1'b1);
    one_beat("add_wrap",  16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1);
    one_beat("or",        16'h00F0, 16'h0F00, 6'b010101, 16'h0FF0, 1'b0, 1'b0);
    @(negedge clk);
    check("basic_drained", out_valid, 0);
    check("basic_op_count", op_count, 6);

    // Fresh count for the stall scenario.
    rst_n = 1'b0;
    #1 check("mid_rst_op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    stall_x[0] = 16'h0001; stall_y[0] = 16'h0001; stall_c[0] = 6'b000010; stall_exp[0] = 16'h0002;
    stall_x[1] = 16'h0002; stall_y[1] = 16'h0002; stall_c[1] = 6'b000010; stall_exp[1] = 16'h0004;
    stall_x[2] = 16'h0010; stall_y[2] = 16'h0030; stall_c[2] = 6'b000000; stall_exp[2] = 16'h0010;
    stall_x[3] = 16'h1234; stall_y[3] = 16'h4321; stall_c[3] = 6'b111111; stall_exp[3] = 16'h0001;

    out_ready = 1'b0;
    x = stall_x[0]; y = stall_y[0]; ctrl = stall_c[0]; in_valid = 1'b1;
    #1 check("stall_in_ready_0", in_ready, 1);
    @(posedge clk);
    #1 x = stall_x[1]; y = stall_y[1]; ctrl = stall_c[1];
    @(negedge clk);
    check("stall_in_ready_1", in_ready, 1);
    @(posedge clk);
    #1 x = stall_x[2]; y = stall_y[2]; ctrl = stall_c[2];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready_low", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_hold", out, stall_exp[0]);
    end

    out_ready = 1'b1;
    idx_in = 2;
    got = 0;
    cyc = 0;
    #1;
    while (got < 4 && cyc < 20) begin
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        check("drain_order", out, stall_exp[got]);
        got++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc_in) begin
        idx_in++;
        if (idx_in < 4) begin
          x = stall_x[idx_in]; y = stall_y[idx_in]; ctrl = stall_c[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("drain_count", got, 4);
    check("drain_cycles", cyc, 4);
    check("stall_op_count", op_count, 4);
    check("stall_empty", out_valid, 0);

    // Two beats in flight, then asynchronous reset.
    out_ready = 1'b0;
    x = 16'h0009; y = 16'h0009; ctrl = 6'b000010; in_valid = 1'b1;
    @(posedge clk);
    #1 x = 16'h0007;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_out", out, 16'h0012);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_out", out, 0);
    check("async_rst_zr", zr, 0);
    check("async_rst_ng", ng, 0);
    check("async_rst_op_count", op_count, 0);
    check("async_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end
    check("no_stale_op_count", op_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
